// File: rtl/pixel_fifo.sv
// pixel_fifo: single-clock pixel FIFO with occupancy flags, sticky
// overflow/underflow, synchronous flush and a selectable read mode
// (registered read or first-word-fall-through).
module pixel_fifo #(
  parameter int WIDTH    = 24,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter bit FWFT     = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       rd_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // storage is never cleared; pointers/count alone define what is readable
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;

  logic full_w, empty_w;
  logic wr_acc, rd_acc;

  // flags come only from the registered count, never from wr_en/rd_en
  assign full_w  = (count_q == CW'(DEPTH));
  assign empty_w = (count_q == '0);

  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (count_q >= CW'(AF_LEVEL));
  assign almost_empty = (count_q <= CW'(AE_LEVEL));
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  // acceptance is judged against start-of-cycle full/empty; flush wins
  assign wr_acc = wr_en & ~full_w  & ~flush;
  assign rd_acc = rd_en & ~empty_w & ~flush;

  // next-state for pointers, occupancy and sticky error flags
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      // pointer width equals log2(DEPTH), so +1 wraps modulo DEPTH
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      // any write attempt while full drops data; any pop while empty is bogus
      if (wr_en && full_w)  ovf_d = 1'b1;
      if (rd_en && empty_w) unf_d = 1'b1;
    end
  end

  // control state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // data array write port
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data;
  end

  generate
    if (FWFT) begin : g_fwft
      // head entry shown directly; zeroed while empty so reset reads as 0
      assign rd_valid = ~empty_w;
      assign rd_data  = empty_w ? '0 : mem_q[rd_ptr_q];
    end else begin : g_reg
      logic [WIDTH-1:0] rd_data_q;
      logic             rd_valid_q;

      // registered read: data lands one cycle after the accepted pop
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else if (flush) begin
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_acc;
          if (rd_acc) rd_data_q <= mem_q[rd_ptr_q];
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_pixel_fifo.sv
// tb_pixel_fifo: directed vectors for pixel_fifo in both read modes.
module tb_pixel_fifo;

  logic        clk;
  int          checks;
  int          failures;

  // registered-read instance
  logic        rst0, flush0, wr0, rd0;
  logic [23:0] wd0, rdd0;
  logic        rv0, full0, empty0, af0, ae0, ovf0, unf0;
  logic [4:0]  cnt0;

  // fwft instance
  logic        rst1, flush1, wr1, rd1;
  logic [23:0] wd1, rdd1;
  logic        rv1, full1, empty1, af1, ae1, ovf1, unf1;
  logic [4:0]  cnt1;

  pixel_fifo #(.FWFT(1'b0)) u0 (
    .clk(clk), .rst(rst0), .flush(flush0), .wr_en(wr0), .wr_data(wd0),
    .rd_en(rd0), .rd_data(rdd0), .rd_valid(rv0), .full(full0), .empty(empty0),
    .almost_full(af0), .almost_empty(ae0), .count(cnt0),
    .overflow(ovf0), .underflow(unf0));

  pixel_fifo #(.FWFT(1'b1)) u1 (
    .clk(clk), .rst(rst1), .flush(flush1), .wr_en(wr1), .wr_data(wd1),
    .rd_en(rd1), .rd_data(rdd1), .rd_valid(rv1), .full(full1), .empty(empty1),
    .almost_full(af1), .almost_empty(ae1), .count(cnt1),
    .overflow(ovf1), .underflow(unf1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required<200000", $time);
    $fatal(1, "timeout");
  end

  typedef struct {
    logic        wr, rd;
    logic [23:0] wd;
    logic [4:0]  cnt;
    logic        full, empty, af, ae, rv, ovf, unf;
    logic        chk_data;
    logic [23:0] rdata;
  } vec_t;

  vec_t vecs[33];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle0;
    wr0 = 1'b0; rd0 = 1'b0; flush0 = 1'b0; wd0 = '0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst0 = 1'b0; rst1 = 1'b0;
    idle0();
    flush1 = 1'b0; wr1 = 1'b0; rd1 = 1'b0; wd1 = '0;

    // fill: 16 writes of 1..16
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{wr:1'b1, rd:1'b0, wd:24'(i+1), cnt:5'(i+1),
                  full:(i==15), empty:1'b0, af:((i+1)>=14), ae:((i+1)<=2),
                  rv:1'b0, ovf:1'b0, unf:1'b0, chk_data:1'b0, rdata:24'h0};
    end
    // drain: 16 reads, data visible the edge after rd_en
    for (int i = 0; i < 16; i++) begin
      vecs[16+i] = '{wr:1'b0, rd:1'b1, wd:24'h0, cnt:5'(15-i),
                     full:1'b0, empty:(i==15), af:((15-i)>=14), ae:((15-i)<=2),
                     rv:1'b1, ovf:1'b0, unf:1'b0, chk_data:1'b1, rdata:24'(i+1)};
    end
    // idle after drain: rd_valid drops, rd_data holds last word
    vecs[32] = '{wr:1'b0, rd:1'b0, wd:24'h0, cnt:5'd0, full:1'b0, empty:1'b1,
                 af:1'b0, ae:1'b1, rv:1'b0, ovf:1'b0, unf:1'b0,
                 chk_data:1'b1, rdata:24'h000010};

    // reset state, checked while rst is still low and before any clock edge
    #2;
    chk("rst.count", 32'(cnt0), 0);
    chk("rst.empty", 32'(empty0), 1);
    chk("rst.ae",    32'(ae0), 1);
    chk("rst.full",  32'(full0), 0);
    chk("rst.af",    32'(af0), 0);
    chk("rst.rv",    32'(rv0), 0);
    chk("rst.ovf",   32'(ovf0), 0);
    chk("rst.unf",   32'(unf0), 0);
    chk("rst.rdata", 32'(rdd0), 0);
    chk("rst1.rv",   32'(rv1), 0);
    chk("rst1.rdata",32'(rdd1), 0);
    #10;
    rst0 = 1'b1; rst1 = 1'b1;
    tick();

    // table-driven fill/drain on the registered-read instance
    for (int i = 0; i < 33; i++) begin
      wr0 = vecs[i].wr; rd0 = vecs[i].rd; wd0 = vecs[i].wd;
      tick();
      chk($sformatf("v%0d.count", i), 32'(cnt0),   32'(vecs[i].cnt));
      chk($sformatf("v%0d.full", i),  32'(full0),  32'(vecs[i].full));
      chk($sformatf("v%0d.empty", i), 32'(empty0), 32'(vecs[i].empty));
      chk($sformatf("v%0d.af", i),    32'(af0),    32'(vecs[i].af));
      chk($sformatf("v%0d.ae", i),    32'(ae0),    32'(vecs[i].ae));
      chk($sformatf("v%0d.rv", i),    32'(rv0),    32'(vecs[i].rv));
      chk($sformatf("v%0d.ovf", i),   32'(ovf0),   32'(vecs[i].ovf));
      chk($sformatf("v%0d.unf", i),   32'(unf0),   32'(vecs[i].unf));
      if (vecs[i].chk_data)
        chk($sformatf("v%0d.rdata", i), 32'(rdd0), 32'(vecs[i].rdata));
    end

    // overflow: full, write+read -> read taken, write dropped, sticky flag
    for (int i = 0; i < 16; i++) begin
      wr0 = 1'b1; wd0 = 24'(32'h100 + i);
      tick();
    end
    idle0();
    chk("ovf.pre_full", 32'(full0), 1);
    wr0 = 1'b1; rd0 = 1'b1; wd0 = 24'hDEAD00;
    tick();
    idle0();
    chk("ovf.count", 32'(cnt0), 15);
    chk("ovf.flag",  32'(ovf0), 1);
    chk("ovf.rdata", 32'(rdd0), 32'h100);
    tick();
    chk("ovf.sticky", 32'(ovf0), 1);
    // drain remaining 15: last word must be 0x10F, never the dropped one
    for (int i = 0; i < 15; i++) begin
      rd0 = 1'b1;
      tick();
      if (rdd0 == 24'hDEAD00) chk("ovf.dropped_seen", 32'(rdd0), 32'h10F);
    end
    idle0();
    chk("ovf.last", 32'(rdd0), 32'h10F);
    chk("ovf.empty", 32'(empty0), 1);
    chk("ovf.sticky2", 32'(ovf0), 1);

    // flush clears overflow
    flush0 = 1'b1;
    tick();
    idle0();
    chk("fl0.ovf", 32'(ovf0), 0);

    // underflow: empty, read+write -> write accepted, read rejected
    wr0 = 1'b1; rd0 = 1'b1; wd0 = 24'h000055;
    tick();
    idle0();
    chk("unf.flag",  32'(unf0), 1);
    chk("unf.count", 32'(cnt0), 1);
    chk("unf.rv",    32'(rv0), 0);
    tick();
    chk("unf.rv2",    32'(rv0), 0);
    chk("unf.sticky", 32'(unf0), 1);

    // build to count 7 then flush with a concurrent write
    for (int i = 0; i < 6; i++) begin
      wr0 = 1'b1; wd0 = 24'(32'h200 + i);
      tick();
    end
    idle0();
    chk("fl.pre_count", 32'(cnt0), 7);
    // also set overflow-free underflow is already 1; flush must clear it
    flush0 = 1'b1; wr0 = 1'b1; wd0 = 24'h777777;
    tick();
    idle0();
    chk("fl.count", 32'(cnt0), 0);
    chk("fl.empty", 32'(empty0), 1);
    chk("fl.ovf",   32'(ovf0), 0);
    chk("fl.unf",   32'(unf0), 0);
    chk("fl.rv",    32'(rv0), 0);

    // fwft: head appears the cycle after the write
    wr1 = 1'b1; wd1 = 24'hABCDEF;
    tick();
    wr1 = 1'b0;
    chk("fw.rv",    32'(rv1), 1);
    chk("fw.rdata", 32'(rdd1), 32'hABCDEF);
    chk("fw.count", 32'(cnt1), 1);
    wr1 = 1'b1; wd1 = 24'h123456;
    tick();
    wr1 = 1'b0;
    chk("fw.head_hold", 32'(rdd1), 32'hABCDEF);
    rd1 = 1'b1;
    tick();
    rd1 = 1'b0;
    chk("fw.pop_next", 32'(rdd1), 32'h123456);
    chk("fw.pop_count", 32'(cnt1), 1);
    wr1 = 1'b1; wd1 = 24'h654321;
    tick();
    wr1 = 1'b0;
    chk("fw.pre_rst_count", 32'(cnt1), 2);
    // asynchronous reset mid-stream, between edges
    #2;
    rst1 = 1'b0;
    #1;
    chk("fw.rst_empty", 32'(empty1), 1);
    chk("fw.rst_count", 32'(cnt1), 0);
    chk("fw.rst_rv",    32'(rv1), 0);
    #3;
    rst1 = 1'b1;
    tick();
    chk("fw.post_rst_empty", 32'(empty1), 1);
    chk("fw.post_rst_rv",    32'(rv1), 0);
    chk("fw.post_rst_rdata", 32'(rdd1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
